// File: rtl/inst_sram_if.sv
// inst_sram_if
// Simple instruction-SRAM request/response bundle between the fetch stage
// (master) and the instruction memory responder (slave).
//   sram_en    : request valid this cycle
//   sram_we    : byte write enables, 0 = read
//   sram_addr  : byte address, bits [1:0] ignored by the responder
//   sram_wdata : write data, lane i = bits [8i+7:8i]
//   sram_rdata : response word, valid the cycle after sram_en
//   sram_rerr  : response is out-of-window, aligned with sram_rdata
interface inst_sram_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_rerr;

  modport master (
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata, sram_rerr
  );

  modport slave (
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata, sram_rerr
  );
endinterface

// File: rtl/inst_sram_responder.sv
// inst_sram_responder
// Word-organised synchronous instruction memory with 1-cycle read latency,
// byte-lane writes, an address-window check and saturating access counters.
// Ports:
//   clk      : clock
//   reset    : synchronous, active-high
//   sram     : inst_sram_if slave side (request in, registered response out)
//   rd_count : accepted read requests (saturating)
//   wr_count : accepted write requests (saturating)
module inst_sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter logic [31:0] FILL_WORD  = 32'h03400000
) (
  input  logic        clk,
  input  logic        reset,
  inst_sram_if.slave  sram,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int          DEPTH        = 1 << ADDR_WIDTH;
  // 33 bits so the window size cannot overflow for wide ADDR_WIDTH.
  localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic                  in_window;
  logic [ADDR_WIDTH-1:0] index;
  logic                  is_write;
  logic                  accept;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of window.
  assign off       = sram.sram_addr - BASE_ADDR;
  assign in_window = ({1'b0, off} < WINDOW_BYTES);
  assign index     = off[ADDR_WIDTH+1:2];
  assign is_write  = |sram.sram_we;
  assign accept    = sram.sram_en && !reset;

  // Array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && in_window) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.sram_we[i]) begin
          mem[index][8*i +: 8] <= sram.sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response register, enabled only by a request so it holds during stalls.
  // Written lanes are forwarded from wdata so a write returns the merged word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram.sram_rdata <= '0;
      sram.sram_rerr  <= 1'b0;
    end else if (sram.sram_en) begin
      if (in_window) begin
        for (int i = 0; i < 4; i++) begin
          sram.sram_rdata[8*i +: 8] <= sram.sram_we[i] ? sram.sram_wdata[8*i +: 8]
                                                       : mem[index][8*i +: 8];
        end
        sram.sram_rerr <= 1'b0;
      end else begin
        sram.sram_rdata <= FILL_WORD;
        sram.sram_rerr  <= 1'b1;
      end
    end
  end

  // Saturating counters; out-of-window requests are counted too.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (sram.sram_en) begin
      if (!is_write && rd_count != 32'hFFFFFFFF) begin
        rd_count <= rd_count + 32'd1;
      end
      if (is_write && wr_count != 32'hFFFFFFFF) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_sram_responder.sv
module tb_inst_sram_responder;

  logic        clk;
  logic        reset;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int checks;
  int errors;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;

  inst_sram_if bus ();

  inst_sram_responder dut (
    .clk      (clk),
    .reset    (reset),
    .sram     (bus.slave),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.sram_en    = en;
    bus.sram_we    = we;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    // Put a known word at 0x1c000000, then reset while a write to it is presented.
    reset = 1'b1;
    idle();
    cycle(); cycle();
    reset = 1'b0;
    drive(1'b1, 4'hF, 32'h1c000000, 32'h12345678);
    cycle();
    reset = 1'b1;
    drive(1'b1, 4'hF, 32'h1c000000, 32'hcafef00d);
    cycle(); cycle(); cycle();
    reset = 1'b0;
    idle();
    checks++;
    if (bus.sram_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected %h", bus.sram_rdata, 32'h0);
    end
    checks++;
    if (bus.sram_rerr !== 1'b0) begin
      errors++; $display("FAIL reset_rerr: got %b expected 0", bus.sram_rerr);
    end
    checks++;
    if (rd_count !== 32'd0) begin
      errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count);
    end
    checks++;
    if (wr_count !== 32'd0) begin
      errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
    end
    exp_rd = 0;
    exp_wr = 0;
    cycle();
    drive(1'b1, 4'h0, 32'h1c000000, 32'h0);
    cycle();
    exp_rd++;
    idle();
    checks++;
    if (bus.sram_rdata !== 32'h12345678) begin
      errors++; $display("FAIL reset_no_write: got %h expected %h", bus.sram_rdata, 32'h12345678);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 4'hF, 32'h1c000010, 32'hdeadbeef);
    cycle();
    exp_wr++;
    checks++;
    if (bus.sram_rdata !== 32'hdeadbeef || bus.sram_rerr !== 1'b0) begin
      errors++; $display("FAIL wr_resp: got %h/%b expected deadbeef/0", bus.sram_rdata, bus.sram_rerr);
    end
    drive(1'b1, 4'h0, 32'h1c000010, 32'h0);
    cycle();
    exp_rd++;
    idle();
    checks++;
    if (bus.sram_rdata !== 32'hdeadbeef || bus.sram_rerr !== 1'b0) begin
      errors++; $display("FAIL rd_resp: got %h/%b expected deadbeef/0", bus.sram_rdata, bus.sram_rerr);
    end
    checks++;
    if (wr_count !== exp_wr || rd_count !== exp_rd) begin
      errors++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 4'b0101, 32'h1c000010, 32'h11223344);
    cycle();
    exp_wr++;
    checks++;
    if (bus.sram_rdata !== 32'hde22be44) begin
      errors++; $display("FAIL lane_wr_resp: got %h expected %h", bus.sram_rdata, 32'hde22be44);
    end
    drive(1'b1, 4'h0, 32'h1c000010, 32'h0);
    cycle();
    exp_rd++;
    checks++;
    if (bus.sram_rdata !== 32'hde22be44) begin
      errors++; $display("FAIL lane_rd_resp: got %h expected %h", bus.sram_rdata, 32'hde22be44);
    end
    // Restore full word for later tests.
    drive(1'b1, 4'hF, 32'h1c000010, 32'hdeadbeef);
    cycle();
    exp_wr++;
    idle();
  endtask

  task automatic test_window();
    drive(1'b1, 4'hF, 32'h1c00fffc, 32'ha5a55a5a);
    cycle();
    exp_wr++;
    drive(1'b1, 4'h0, 32'h1bfffffc, 32'h0);
    cycle();
    exp_rd++;
    checks++;
    if (bus.sram_rdata !== 32'h03400000 || bus.sram_rerr !== 1'b1) begin
      errors++; $display("FAIL win_below: got %h/%b expected 03400000/1", bus.sram_rdata, bus.sram_rerr);
    end
    drive(1'b1, 4'h0, 32'h1c010000, 32'h0);
    cycle();
    exp_rd++;
    checks++;
    if (bus.sram_rdata !== 32'h03400000 || bus.sram_rerr !== 1'b1) begin
      errors++; $display("FAIL win_above: got %h/%b expected 03400000/1", bus.sram_rdata, bus.sram_rerr);
    end
    drive(1'b1, 4'h0, 32'h1c00fffc, 32'h0);
    cycle();
    exp_rd++;
    checks++;
    if (bus.sram_rdata !== 32'ha5a55a5a || bus.sram_rerr !== 1'b0) begin
      errors++; $display("FAIL win_last: got %h/%b expected a5a55a5a/0", bus.sram_rdata, bus.sram_rerr);
    end
    // Out-of-window write: would alias index 0 if the window check were missing.
    drive(1'b1, 4'hF, 32'h1c010000, 32'h55555555);
    cycle();
    exp_wr++;
    checks++;
    if (bus.sram_rdata !== 32'h03400000 || bus.sram_rerr !== 1'b1) begin
      errors++; $display("FAIL win_wr_resp: got %h/%b expected 03400000/1", bus.sram_rdata, bus.sram_rerr);
    end
    drive(1'b1, 4'h0, 32'h1c000000, 32'h0);
    cycle();
    exp_rd++;
    checks++;
    if (bus.sram_rdata !== 32'h12345678 || bus.sram_rerr !== 1'b0) begin
      errors++; $display("FAIL win_wr_dropped: got %h/%b expected 12345678/0", bus.sram_rdata, bus.sram_rerr);
    end
    // Low address bits are ignored.
    drive(1'b1, 4'h0, 32'h1c000013, 32'h0);
    cycle();
    exp_rd++;
    idle();
    checks++;
    if (bus.sram_rdata !== 32'hdeadbeef) begin
      errors++; $display("FAIL unaligned_rd: got %h expected deadbeef", bus.sram_rdata);
    end
    checks++;
    if (wr_count !== exp_wr || rd_count !== exp_rd) begin
      errors++; $display("FAIL win_counts: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 4'h0, 32'h1c000010, 32'h0);
    cycle();
    exp_rd++;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'(k), 32'h1bfffff0 + 32'(k * 4), 32'hffffffff);
      cycle();
      checks++;
      if (bus.sram_rdata !== 32'hdeadbeef || bus.sram_rerr !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got %h/%b expected deadbeef/0", k, bus.sram_rdata, bus.sram_rerr);
      end
    end
    idle();
    checks++;
    if (rd_count !== exp_rd || wr_count !== exp_wr) begin
      errors++; $display("FAIL hold_counts: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                         rd_count, wr_count, exp_rd, exp_wr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_start;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'hF, 32'h1c000000 + 32'(i * 4), 32'(i));
      cycle();
      exp_wr++;
    end
    rd_start = rd_count;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'h0, 32'h1c000000 + 32'(i * 4), 32'h0);
      cycle();
      exp_rd++;
      checks++;
      if (bus.sram_rdata !== 32'(i)) begin
        errors++; $display("FAIL stream_%0d: got %h expected %h", i, bus.sram_rdata, 32'(i));
      end
    end
    idle();
    checks++;
    if (rd_count - rd_start !== 32'd16) begin
      errors++; $display("FAIL stream_count: got delta %0d expected 16", rd_count - rd_start);
    end
    // Write then read of the same index on consecutive cycles.
    drive(1'b1, 4'hF, 32'h1c000040, 32'h00000077);
    cycle();
    exp_wr++;
    drive(1'b1, 4'h0, 32'h1c000040, 32'h0);
    cycle();
    exp_rd++;
    idle();
    checks++;
    if (bus.sram_rdata !== 32'h00000077) begin
      errors++; $display("FAIL wr_then_rd: got %h expected 00000077", bus.sram_rdata);
    end
    checks++;
    if (wr_count !== exp_wr || rd_count !== exp_rd) begin
      errors++; $display("FAIL final_counts: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                         wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_rd = 0;
    exp_wr = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_window();
    test_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
